// File: rtl/vect_result_stage.sv
// Vector result stage: collects ALU element results and emits elementwise writebacks,
// a reduction scalar, or a packed mask. Define VRED_MINMAX_EN to enable min/max reductions.
module vect_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [2:0]                red_op_i,
  input  logic [$clog2(MAX_VL):0]   vl_i,
  input  logic [DATA_WIDTH-1:0]     init_i,
  input  logic                      elem_valid_i,
  input  logic [DATA_WIDTH-1:0]     elem_i,
  input  logic                      elem_mask_i,
  output logic                      elem_ready_o,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic [$clog2(MAX_VL)-1:0] wb_idx_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int CW = $clog2(MAX_VL) + 1;
  localparam int IW = $clog2(MAX_VL);

  localparam logic [1:0] MODE_EW   = 2'd0;
  localparam logic [1:0] MODE_PACK = 2'd2;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              mode_reg;
  logic [2:0]              op_reg;
  logic [CW-1:0]           vl_reg;
  logic [CW-1:0]           cnt_reg;
  logic [DATA_WIDTH-1:0]   acc_reg;
  logic                    wb_valid_reg;
  logic [DATA_WIDTH-1:0]   wb_data_reg;
  logic [IW-1:0]           wb_idx_reg;
  logic                    done_reg;
  logic                    last_pend_reg;

  logic                    elem_ready;
  logic                    start_ok;
  logic                    accept;
  logic                    wb_fire;
  logic [CW-1:0]           cnt_inc;
  logic                    is_last;
  logic [DATA_WIDTH-1:0]   red_result;
  logic [DATA_WIDTH-1:0]   pack_next;
  logic [DATA_WIDTH-1:0]   acc_next;

  // A new instruction waits for any trailing elementwise write to drain.
  assign start_ok = (state_reg == IDLE) && start_i && !wb_valid_reg;
  assign accept   = elem_valid_i && elem_ready;
  assign wb_fire  = wb_valid_reg && wb_ready_i;
  assign cnt_inc  = cnt_reg + CW'(1);
  assign is_last  = (cnt_inc == vl_reg);

  always_comb begin
    elem_ready = 1'b0;
    if (state_reg == COLLECT) begin
      elem_ready = (mode_reg != MODE_EW) || !wb_valid_reg || wb_ready_i;
    end
  end

  always_comb begin
    red_result = acc_reg;
    case (op_reg)
      3'd0: red_result = acc_reg + elem_i;
      3'd1: red_result = acc_reg & elem_i;
      3'd2: red_result = acc_reg | elem_i;
      3'd3: red_result = acc_reg ^ elem_i;
`ifdef VRED_MINMAX_EN
      3'd4: red_result = ($signed(elem_i) < $signed(acc_reg)) ? elem_i : acc_reg;
      3'd5: red_result = (elem_i < acc_reg) ? elem_i : acc_reg;
      3'd6: red_result = ($signed(elem_i) > $signed(acc_reg)) ? elem_i : acc_reg;
      3'd7: red_result = (elem_i > acc_reg) ? elem_i : acc_reg;
`endif
      default: red_result = acc_reg;
    endcase
  end

  // Only bit positions reachable by an element index can ever be written.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pack
    if (gi < MAX_VL) begin : g_live
      assign pack_next[gi] = (cnt_reg == CW'(gi)) ? (elem_mask_i & elem_i[0]) : acc_reg[gi];
    end else begin : g_dead
      assign pack_next[gi] = acc_reg[gi];
    end
  end

  always_comb begin
    acc_next = acc_reg;
    if (mode_reg == MODE_PACK) begin
      acc_next = pack_next;
    end else if (elem_mask_i) begin
      acc_next = red_result;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok && (vl_i != '0)) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && is_last) begin
          state_next = (mode_reg == MODE_EW) ? IDLE : WRITE;
        end
      end
      WRITE: begin
        if (wb_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_reg      <= '0;
      op_reg        <= '0;
      vl_reg        <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      wb_valid_reg  <= 1'b0;
      wb_data_reg   <= '0;
      wb_idx_reg    <= '0;
      done_reg      <= 1'b0;
      last_pend_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (wb_fire) begin
        wb_valid_reg  <= 1'b0;
        last_pend_reg <= 1'b0;
        if (last_pend_reg || (state_reg == WRITE)) begin
          done_reg <= 1'b1;
        end
      end

      if (start_ok) begin
        mode_reg      <= (mode_i == 2'd3) ? MODE_EW : mode_i;
        op_reg        <= red_op_i;
        vl_reg        <= vl_i;
        cnt_reg       <= '0;
        acc_reg       <= (mode_i == MODE_PACK) ? '0 : init_i;
        last_pend_reg <= 1'b0;
        if (vl_i == '0) begin
          done_reg <= 1'b1;
        end
      end

      // Later assignments here override the drain of a write handshaking this cycle.
      if (accept) begin
        cnt_reg <= cnt_inc;
        if (mode_reg == MODE_EW) begin
          if (elem_mask_i) begin
            wb_valid_reg  <= 1'b1;
            wb_data_reg   <= elem_i;
            wb_idx_reg    <= cnt_reg[IW-1:0];
            last_pend_reg <= is_last;
          end else if (is_last) begin
            done_reg <= 1'b1;
          end
        end else begin
          acc_reg <= acc_next;
          if (is_last) begin
            wb_valid_reg <= 1'b1;
            wb_data_reg  <= acc_next;
            wb_idx_reg   <= '0;
          end
        end
      end
    end
  end

  assign elem_ready_o = elem_ready;
  assign wb_valid_o   = wb_valid_reg;
  assign wb_data_o    = wb_data_reg;
  assign wb_idx_o     = wb_idx_reg;
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = done_reg;

endmodule

// File: tb/tb_vect_result_stage.sv
// Self-checking bench for vect_result_stage: directed vector table, hand sequences,
// and randomized instructions checked against a behavioural reference model.
module tb_vect_result_stage;
  localparam int DW  = 32;
  localparam int MVL = 32;

`ifdef VRED_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [2:0]    red_op_i;
  logic [5:0]    vl_i;
  logic [31:0]   init_i;
  logic          elem_valid_i;
  logic [31:0]   elem_i;
  logic          elem_mask_i;
  logic          elem_ready_o;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [31:0]   wb_data_o;
  logic [4:0]    wb_idx_o;
  logic          busy_o;
  logic          done_o;

  vect_result_stage #(.DATA_WIDTH(DW), .MAX_VL(MVL)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .red_op_i(red_op_i), .vl_i(vl_i), .init_i(init_i),
    .elem_valid_i(elem_valid_i), .elem_i(elem_i), .elem_mask_i(elem_mask_i),
    .elem_ready_o(elem_ready_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_idx_o(wb_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the monitor process)
  logic [31:0] mon_data[$];
  int          mon_idx[$];
  int          done_cnt = 0;
  int          stall_err = 0;
  int          stall_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [4:0]  prev_idx = '0;

  // Ready driver state
  int cyc = 0;
  int stall_until = 0;
  bit rand_ready_en = 1'b0;

  logic [31:0] cur_elems[32];
  logic [31:0] cur_mask;

  typedef struct packed {
    logic [1:0]       mode;
    logic [2:0]       op;
    logic [5:0]       vl;
    logic [31:0]      init;
    logic [7:0][31:0] elems;   // concatenation lists element 7 first
    logic [7:0]       mask;    // bit i = element i active
    logic [31:0]      exp;
  } vec_t;

  vec_t tbl[12];

  always @(negedge clk) begin
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_seen++;
        if (!wb_valid_o || wb_data_o !== prev_data || wb_idx_o !== prev_idx) stall_err++;
      end
      if (wb_valid_o && wb_ready_i) begin
        mon_data.push_back(wb_data_o);
        mon_idx.push_back(int'(wb_idx_o));
      end
      if (done_o) done_cnt++;
      prev_stall = wb_valid_o && !wb_ready_i;
      prev_data  = wb_data_o;
      prev_idx   = wb_idx_o;
    end
  end

  initial begin
    wb_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < stall_until) wb_ready_i = 1'b0;
      else if (rand_ready_en) wb_ready_i = ($urandom_range(0, 3) != 0);
      else wb_ready_i = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] m, input logic [2:0] op,
                                            input int vl, input logic [31:0] init);
    logic [31:0] r;
    logic [31:0] e;
    if (m == 2'd2) begin
      r = '0;
      for (int i = 0; i < vl; i++) r[i] = cur_mask[i] & cur_elems[i][0];
      return r;
    end
    r = init;
    for (int i = 0; i < vl; i++) begin
      e = cur_elems[i];
      if (cur_mask[i]) begin
        case (op)
          3'd0: r = r + e;
          3'd1: r = r & e;
          3'd2: r = r | e;
          3'd3: r = r ^ e;
          3'd4: if (MM && $signed(e) < $signed(r)) r = e;
          3'd5: if (MM && e < r) r = e;
          3'd6: if (MM && $signed(e) > $signed(r)) r = e;
          default: if (MM && e > r) r = e;
        endcase
      end
    end
    return r;
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [2:0] op,
                          input logic [5:0] vl, input logic [31:0] init);
    start_i = 1'b1; mode_i = m; red_op_i = op; vl_i = vl; init_i = init;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int n, input string name);
    int guard;
    for (int i = 0; i < n; i++) begin
      elem_valid_i = 1'b1;
      elem_i       = cur_elems[i];
      elem_mask_i  = cur_mask[i];
      #1;
      guard = 0;
      while (!elem_ready_o && guard < 300) begin
        @(posedge clk); #2;
        guard++;
      end
      if (guard >= 300) begin
        chk({name, "_feed_timeout"}, 32'(elem_ready_o), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    elem_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int db, input string name);
    int g = 0;
    while (done_cnt == db && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (done_cnt == db) chk({name, "_done_timeout"}, 32'(done_cnt - db), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [1:0] m, input logic [2:0] op, input logic [5:0] vl,
                           input logic [31:0] init, input logic [31:0] exp, input string name);
    int qb = mon_data.size();
    int db = done_cnt;
    do_start(m, op, vl, init);
    feed(int'(vl), name);
    wait_done(db, name);
    chk({name, "_nwrites"}, 32'(mon_data.size() - qb), 32'd1);
    if (mon_data.size() > qb) begin
      chk({name, "_data"}, mon_data[qb], exp);
      chk({name, "_idx"}, 32'(mon_idx[qb]), 32'd0);
    end
    chk({name, "_done"}, 32'(done_cnt - db), 32'd1);
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_ew(input logic [1:0] m, input logic [5:0] vl, input string name);
    int          qb = mon_data.size();
    int          db = done_cnt;
    int          exp_idx[$];
    logic [31:0] exp_data[$];
    for (int i = 0; i < int'(vl); i++) begin
      if (cur_mask[i]) begin
        exp_idx.push_back(i);
        exp_data.push_back(cur_elems[i]);
      end
    end
    do_start(m, 3'd0, vl, 32'hDEAD_BEEF);
    feed(int'(vl), name);
    wait_done(db, name);
    chk({name, "_nwrites"}, 32'(mon_data.size() - qb), 32'(exp_data.size()));
    for (int k = 0; k < exp_data.size() && qb + k < mon_data.size(); k++) begin
      chk($sformatf("%s_w%0d_idx", name, k), 32'(mon_idx[qb + k]), 32'(exp_idx[k]));
      chk($sformatf("%s_w%0d_data", name, k), mon_data[qb + k], exp_data[k]);
    end
    chk({name, "_done"}, 32'(done_cnt - db), 32'd1);
  endtask

  initial begin
    int db, qb;
    logic [1:0] rm;
    logic [5:0] rvl;
    logic [2:0] rop;
    logic [31:0] rinit;

    reset_i = 1'b1; start_i = 1'b0; mode_i = '0; red_op_i = '0; vl_i = '0; init_i = '0;
    elem_valid_i = 1'b0; elem_i = '0; elem_mask_i = 1'b0; cur_mask = '0;
    for (int i = 0; i < 32; i++) cur_elems[i] = '0;

    tbl[0]  = '{2'd1, 3'd0, 6'd4, 32'd10,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd3, 32'd2, 32'd1}, 8'h0F, 32'd20};
    tbl[1]  = '{2'd1, 3'd4, 6'd2, 32'd0,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF}, 8'h03,
                MM ? 32'hFFFF_FFFF : 32'd0};
    tbl[2]  = '{2'd1, 3'd5, 6'd2, 32'd0,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF}, 8'h03, 32'd0};
    tbl[3]  = '{2'd2, 3'd0, 6'd5, 32'hFFFF_FFFF,
                {32'd0, 32'd0, 32'd0, 32'd5, 32'd7, 32'd2, 32'd3, 32'd1}, 8'h17, 32'h13};
    tbl[4]  = '{2'd1, 3'd1, 6'd3, 32'hFFFF_00FF,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0F0F_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0},
                8'h05, 32'h0000_00F0};
    tbl[5]  = '{2'd1, 3'd2, 6'd3, 32'd0,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd2, 32'd1}, 8'h03, 32'd3};
    tbl[6]  = '{2'd1, 3'd3, 6'd2, 32'hAAAA_5555,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_FFFF, 32'hFFFF_FFFF},
                8'h03, 32'h5555_5555};
    tbl[7]  = '{2'd1, 3'd0, 6'd2, 32'hFFFF_FFFF,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1}, 8'h03, 32'd2};
    tbl[8]  = '{2'd1, 3'd6, 6'd3, 32'h8000_0000,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'h7FFF_FFFF},
                8'h07, MM ? 32'h7FFF_FFFF : 32'h8000_0000};
    tbl[9]  = '{2'd1, 3'd7, 6'd2, 32'd0,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000},
                8'h03, MM ? 32'h8000_0000 : 32'd0};
    tbl[10] = '{2'd2, 3'd0, 6'd8, 32'd0,
                {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1}, 8'hFF, 32'hFF};
    tbl[11] = '{2'd1, 3'd4, 6'd2, 32'd5,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFF0},
                8'h02, MM ? 32'd3 : 32'd5};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_elem_ready", 32'(elem_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_wb_idx", 32'(wb_idx_o), 32'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Directed vector table
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 8; i++) cur_elems[i] = tbl[k].elems[i];
      cur_mask = {24'd0, tbl[k].mask};
      run_instr(tbl[k].mode, tbl[k].op, tbl[k].vl, tbl[k].init, tbl[k].exp,
                $sformatf("vec%0d", k));
    end

    // Elementwise with a writeback stall
    cur_elems[0] = 32'hA0A0_0000; cur_elems[1] = 32'hB1B1_1111; cur_elems[2] = 32'hC2C2_2222;
    cur_mask = 32'b101;
    stall_until = cyc + 5;
    run_ew(2'd0, 6'd3, "ew_stall");
    chk("ew_stall_observed", 32'(stall_seen != 0), 32'd1);

    // Zero-length instruction
    qb = mon_data.size();
    do_start(2'd1, 3'd0, 6'd0, 32'd7);
    chk("vl0_done_pulse", 32'(done_o), 32'd1);
    chk("vl0_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    chk("vl0_done_single", 32'(done_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("vl0_no_write", 32'(mon_data.size() - qb), 32'd0);

    // Start while busy is ignored
    qb = mon_data.size();
    db = done_cnt;
    cur_elems[0] = 32'd1; cur_elems[1] = 32'd2; cur_mask = 32'b11;
    do_start(2'd1, 3'd0, 6'd2, 32'd5);
    do_start(2'd2, 3'd3, 6'd1, 32'd99);
    chk("busy_during_collect", 32'(busy_o), 32'd1);
    feed(2, "busy_start");
    wait_done(db, "busy_start");
    chk("busy_start_nwrites", 32'(mon_data.size() - qb), 32'd1);
    if (mon_data.size() > qb) chk("busy_start_data", mon_data[qb], 32'd8);
    chk("busy_start_done", 32'(done_cnt - db), 32'd1);

    // Reset in the middle of a sum
    for (int i = 0; i < 8; i++) cur_elems[i] = 32'(i + 1);
    cur_mask = 32'hFF;
    qb = mon_data.size();
    db = done_cnt;
    do_start(2'd1, 3'd0, 6'd8, 32'd0);
    feed(3, "midrst");
    chk("midrst_busy_before", 32'(busy_o), 32'd1);
    elem_valid_i = 1'b1;
    reset_i = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_elem_ready", 32'(elem_ready_o), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_wb_data", wb_data_o, 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    elem_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - db), 32'd0);
    chk("midrst_no_write", 32'(mon_data.size() - qb), 32'd0);
    run_instr(2'd1, 3'd0, 6'd8, 32'd0, 32'd36, "after_rst_sum");

    // Randomized reductions and mask-packs
    rand_ready_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      rm    = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd1;
      rop   = 3'($urandom_range(0, 7));
      rvl   = 6'($urandom_range(1, 20));
      rinit = $urandom;
      cur_mask = $urandom;
      for (int i = 0; i < 32; i++)
        cur_elems[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
      run_instr(rm, rop, rvl, rinit, ref_model(rm, rop, int'(rvl), rinit),
                $sformatf("rnd%0d_m%0d_op%0d_vl%0d", r, rm, rop, rvl));
    end

    // Randomized elementwise (mode 3 behaves as elementwise)
    for (int r = 0; r < 15; r++) begin
      rm  = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
      rvl = 6'($urandom_range(1, 20));
      cur_mask = $urandom;
      for (int i = 0; i < 32; i++) cur_elems[i] = $urandom;
      run_ew(rm, rvl, $sformatf("rew%0d_m%0d_vl%0d", r, rm, rvl));
    end
    rand_ready_en = 1'b0;

    chk("wb_stable_under_stall", 32'(stall_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
